dnn_feeder: RTL and testbench

Stimulus-and-scoreboard engine that drives the `dnn` input stream and consumes its classification result. Software or a loader writes one sample (`num_weight_layer1` input words plus a truth label) into an internal buffer. A `start` pulse then replays the words on `x_data`/`x_valid` and waits for `class_valid`. The block compares `class_id` with the label and keeps pass/run counters. It sits in front of `dnn` in the on-chip self-test path, on the transmit side of the `x_data`/`x_valid` → `class_id`/`class_valid` interface.

---
 rtl/nn_config_pkg.sv | 20 ++
 rtl/sample_buf.sv | 23 ++
 rtl/dnn_feeder.sv | 156 +++++++++++++++
 tb/tb_dnn_feeder.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/nn_config_pkg.sv
// Shared configuration for the dnn datapath and its self-test feeder.
package nn_config_pkg;

    localparam int num_weight_layer1 = 784;
    localparam int sig_size          = 10;
    localparam int class_width       = $clog2(sig_size);
    localparam int feeder_timeout    = 4096;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sample_buf.sv
// Sample storage: one write port, one combinational read port, no reset.
module sample_buf #(
    parameter int data_width = 16,
    parameter int depth      = 785,
    parameter int aw         = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [aw-1:0]         waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [aw-1:0]         raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem_q [depth];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dnn_feeder.sv
// Replays a buffered sample into dnn, waits for its class result and scores
// it against the stored truth label.
module dnn_feeder #(
    parameter int data_width     = 16,
    parameter int num_inputs     = nn_config_pkg::num_weight_layer1,
    parameter int timeout_cycles = nn_config_pkg::feeder_timeout,
    parameter int class_width    = nn_config_pkg::class_width,
    parameter int aw             = $clog2(num_inputs + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_we,
    input  logic [aw-1:0]          load_addr,
    input  logic [data_width-1:0]  load_data,
    input  logic                   start,
    output logic                   busy,
    output logic [data_width-1:0]  x_data,
    output logic                   x_valid,
    input  logic [class_width-1:0] class_id,
    input  logic                   class_valid,
    output logic                   result_valid,
    output logic                   pass,
    output logic                   timeout,
    output logic [class_width-1:0] result_class,
    output logic [15:0]            run_cnt,
    output logic [15:0]            pass_cnt
);
    import nn_config_pkg::*;

    localparam int TW = $clog2(timeout_cycles + 1);

    feeder_state_t         state_q, state_d;
    logic [aw-1:0]         idx_q, idx_d, rd_addr;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [data_width-1:0] x_data_q, x_data_d, buf_rdata, rd_word;
    logic                  x_valid_q, x_valid_d, rv_q, rv_d;
    logic                  pass_q, pass_d, to_q, to_d;
    logic [class_width-1:0] rc_q, rc_d;
    logic [15:0]           run_q, run_d, pcnt_q, pcnt_d;
    logic                  wr_en, label_ok;

    assign wr_en = load_we && (state_q == IDLE) && (load_addr <= aw'(num_inputs));

    // IDLE reads word 0 so the first word goes out on the start edge; WAIT
    // parks the read port on the label for scoring.
    always_comb begin
        rd_addr = aw'(num_inputs);
        if (state_q == IDLE)   rd_addr = '0;
        if (state_q == STREAM) rd_addr = idx_q;
    end

    // Same-cycle load+start must stream the freshly written word.
    assign rd_word  = (wr_en && load_addr == rd_addr) ? load_data : buf_rdata;
    assign label_ok = (rd_word[class_width-1:0] == class_id) &&
                      (rd_word[data_width-1:class_width] == '0);

    sample_buf #(.data_width(data_width), .depth(num_inputs + 1), .aw(aw)) u_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (rd_addr),
        .rdata (buf_rdata)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tcnt_d    = tcnt_q;
        x_data_d  = x_data_q;
        x_valid_d = x_valid_q;
        rv_d      = 1'b0;
        pass_d    = pass_q;
        to_d      = to_q;
        rc_d      = rc_q;
        run_d     = run_q;
        pcnt_d    = pcnt_q;
        case (state_q)
            IDLE: if (start) begin
                x_data_d  = rd_word;
                x_valid_d = 1'b1;
                idx_d     = aw'(1);
                tcnt_d    = '0;
                state_d   = (num_inputs == 1) ? WAIT : STREAM;
            end
            STREAM: begin
                x_data_d  = rd_word;
                x_valid_d = 1'b1;
                idx_d     = idx_q + 1'b1;
                tcnt_d    = '0;
                if (idx_q == aw'(num_inputs - 1)) state_d = WAIT;
            end
            WAIT: begin
                x_data_d  = '0;
                x_valid_d = 1'b0;
                tcnt_d    = tcnt_q + 1'b1;
                if (class_valid) begin
                    state_d = DONE;
                    rv_d    = 1'b1;
                    rc_d    = class_id;
                    to_d    = 1'b0;
                    pass_d  = label_ok;
                    run_d   = sat_inc16(run_q);
                    if (label_ok) pcnt_d = sat_inc16(pcnt_q);
                end else if (tcnt_q == TW'(timeout_cycles - 1)) begin
                    state_d = DONE;
                    rv_d    = 1'b1;
                    rc_d    = '0;
                    to_d    = 1'b1;
                    pass_d  = 1'b0;
                    run_d   = sat_inc16(run_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            tcnt_q    <= '0;
            x_data_q  <= '0;
            x_valid_q <= 1'b0;
            rv_q      <= 1'b0;
            pass_q    <= 1'b0;
            to_q      <= 1'b0;
            rc_q      <= '0;
            run_q     <= '0;
            pcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tcnt_q    <= tcnt_d;
            x_data_q  <= x_data_d;
            x_valid_q <= x_valid_d;
            rv_q      <= rv_d;
            pass_q    <= pass_d;
            to_q      <= to_d;
            rc_q      <= rc_d;
            run_q     <= run_d;
            pcnt_q    <= pcnt_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign x_data       = x_data_q;
    assign x_valid      = x_valid_q;
    assign result_valid = rv_q;
    assign pass         = pass_q;
    assign timeout      = to_q;
    assign result_class = rc_q;
    assign run_cnt      = run_q;
    assign pass_cnt     = pcnt_q;

endmodule

// File: tb/tb_dnn_feeder.sv
// Directed bench for dnn_feeder with a behavioural dnn responder.
module tb_dnn_feeder;
    import nn_config_pkg::*;

    localparam int N  = num_weight_layer1;
    localparam int T  = 40;
    localparam int AW = $clog2(N + 1);
    localparam int CW = class_width;

    logic          clk = 1'b0, rst = 1'b1;
    logic          load_we = 1'b0, start = 1'b0, class_valid = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [15:0]   load_data = '0;
    logic [CW-1:0] class_id = '0;
    logic          busy, x_valid, result_valid, pass, timeout;
    logic [15:0]   x_data, run_cnt, pass_cnt;
    logic [CW-1:0] result_class;

    dnn_feeder #(.timeout_cycles(T)) dut (
        .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .start(start), .busy(busy), .x_data(x_data),
        .x_valid(x_valid), .class_id(class_id), .class_valid(class_valid),
        .result_valid(result_valid), .pass(pass), .timeout(timeout),
        .result_class(result_class), .run_cnt(run_cnt), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    int          nvec = 0, nerr = 0;
    logic [15:0] exp_word [N+1];
    int          nvalid, dmis, since, got_rv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic load(input int a, input logic [15:0] d);
        @(negedge clk);
        load_we = 1'b1; load_addr = AW'(a); load_data = d;
        if (a <= N) exp_word[a] = d;
        @(negedge clk);
        load_we = 1'b0;
    endtask

    // resp < 0: responder stays silent. mid >= 0: start + loads attempted mid-stream.
    task automatic run(input int resp, input logic [CW-1:0] cls, input int mid,
                       input bit ld, input int ld_a, input logic [15:0] ld_d,
                       input bit e_pass, input bit e_to, input logic [CW-1:0] e_rc,
                       input int e_run, input int e_pcnt);
        @(negedge clk);
        start = 1'b1;
        if (ld) begin
            load_we = 1'b1; load_addr = AW'(ld_a); load_data = ld_d; exp_word[ld_a] = ld_d;
        end
        @(negedge clk);
        start = 1'b0; load_we = 1'b0;
        chk("first_xv", x_valid, 1);
        chk("busy_run", busy, 1);
        nvalid = 0; dmis = 0; since = 0; got_rv = 0;
        for (int c = 0; c < 2000; c++) begin
            if (result_valid) begin got_rv = 1; break; end
            if (x_valid) begin
                if (since != 0 || nvalid >= N || x_data !== exp_word[nvalid]) dmis++;
                nvalid++;
            end else if (nvalid > 0) since++;
            start     = (mid >= 0 && nvalid == mid);
            load_we   = (mid >= 0 && (nvalid == mid || nvalid == mid + 1));
            load_addr = (nvalid == mid) ? AW'(N) : AW'(5);
            load_data = (nvalid == mid) ? 16'h0003 : 16'hDEAD;
            class_valid = (resp >= 0 && since == resp && nvalid > 0);
            class_id    = cls;
            @(negedge clk);
        end
        start = 1'b0; load_we = 1'b0; class_valid = 1'b0;
        chk("rv_seen", got_rv, 1);
        chk("nwords", nvalid, N);
        chk("stream_data", dmis, 0);
        chk("rv_latency", since, (resp >= 0) ? resp : T - 1);
        chk("rv_busy", busy, 1);
        chk("pass", pass, e_pass);
        chk("timeout", timeout, e_to);
        chk("result_class", result_class, e_rc);
        chk("run_cnt", run_cnt, e_run);
        chk("pass_cnt", pass_cnt, e_pcnt);
        @(negedge clk);
        chk("rv_pulse", result_valid, 0);
        chk("back_idle", busy, 0);
        chk("pass_held", pass, e_pass);
    endtask

    initial begin
        #2 rst = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_xv", x_valid, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_run", run_cnt, 0);
        chk("rst_pcnt", pass_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Sample i -> i, label 7
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            load_we = 1'b1; load_addr = AW'(i); load_data = 16'(i); exp_word[i] = 16'(i);
            @(negedge clk);
        end
        load_we = 1'b0;
        load(N, 16'd7);

        run(30, 4'd7, -1, 0, 0, 16'h0, 1, 0, 4'd7, 1, 1);
        run(30, 4'd3, -1, 0, 0, 16'h0, 0, 0, 4'd3, 2, 1);
        run(-1, 4'd0, -1, 0, 0, 16'h0, 0, 1, 4'd0, 3, 1);
        // label overwrite and word-5 overwrite while busy must both be dropped
        run(5, 4'd7, 200, 0, 0, 16'h0, 1, 0, 4'd7, 4, 2);
        repeat (5) @(negedge clk);
        chk("no_rerun_busy", busy, 0);
        chk("no_rerun_cnt", run_cnt, 4);
        // load word 0 in the same cycle as start
        run(8, 4'd7, -1, 1, 0, 16'h1234, 1, 0, 4'd7, 5, 3);

        // Reset mid-stream at word 100
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (100) @(negedge clk);
        chk("pre_rst_xv", x_valid, 1);
        chk("pre_rst_word", x_data, exp_word[100]);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_xv", x_valid, 0);
        chk("mid_rst_xd", x_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_run", run_cnt, 0);
        chk("mid_rst_pcnt", pass_cnt, 0);
        chk("mid_rst_pass", pass, 0);
        chk("mid_rst_rc", result_class, 0);
        @(negedge clk); rst = 1'b1;
        run(10, 4'd7, -1, 0, 0, 16'h0, 1, 0, 4'd7, 1, 1);

        // Upper label bits nonzero never match
        load(N, 16'h0107);
        run(10, 4'd7, -1, 0, 0, 16'h0, 0, 0, 4'd7, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
